ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Round-robin arbiter sharing one port of the synchronous dual-port RAM between
//  NUM_M requesters (e.g. instruction fetch, load/store unit, debug/DMA).
//  Grants at most one access per cycle. Drives the RAM port combinationally.
//  Returns read data one cycle later, matching the RAM's registered read.
// PARAMETERS
//  NUM_M      2   number of requesters, 2..8
//  dat_width  32  data width, equal to the RAM dat_width
//  adr_width  32  word-address width, equal to the RAM adr_width
// PORTS
//  clk        in   1              rising-edge clock, shared with the RAM
//  rst_n      in   1              asynchronous active-low reset
//  m_req_i    in   NUM_M          per-requester access request
//  m_we_i     in   NUM_M          per-requester write enable (1=write, 0=read)
//  m_adr_i    in   NUM_M*adr_width  word addresses; requester k in slice k
//  m_wdat_i   in   NUM_M*dat_width  write data; requester k in slice k
//  m_ack_o    out  NUM_M          one-hot grant, same cycle as the request
//  m_resp_o   out  NUM_M          one-hot read-response valid
//  m_rdat_o   out  dat_width      read data, shared; valid where m_resp_o is set
//  ram_adr_o  out  adr_width      to RAM adrN_i
//  ram_we_o   out  1              to RAM weN_i
//  ram_dat_o  out  dat_width      to RAM datN_i
//  ram_dat_i  in   dat_width      from RAM datN_o
// BEHAVIOUR
//  - State: rr_ptr (log2 NUM_M bits), resp_pend (1 bit), resp_id (log2 NUM_M bits).
//  - Reset (async, rst_n=0): rr_ptr=0, resp_pend=0, resp_id=0.
//    Therefore m_resp_o=0. m_ack_o and ram_we_o follow m_req_i combinationally,
//    but are forced to 0 while rst_n=0.
//  - Arbitration (combinational): search m_req_i starting at index rr_ptr, upward
//    with wrap-around. The first asserted index g is granted: m_ack_o[g]=1.
//    No other ack bits are set.
//  - On a grant: ram_adr_o = slice g of m_adr_i, ram_we_o = m_we_i[g],
//    ram_dat_o = slice g of m_wdat_i.
//  - With no request: ram_we_o=0, ram_adr_o=0, ram_dat_o=0.
//  - Handshake: a request is accepted in the cycle where req & ack. A requester
//    holds req, we, adr and wdat stable until acked. It may drop req before the
//    ack, and nothing is then accepted for it.
//  - Pointer update: on each grant, rr_ptr <= (g+1) mod NUM_M. With no grant,
//    rr_ptr holds. A continuously requesting master is served at least once every
//    NUM_M cycles.
//  - Read latency is exactly 1 cycle. A granted read sets resp_pend<=1 and
//    resp_id<=g. Next cycle: m_resp_o[resp_id]=1 and m_rdat_o=ram_dat_i.
//  - m_rdat_o = ram_dat_i at all times; only m_resp_o qualifies it.
//  - Writes produce no response and leave resp_pend cleared. A granted write's
//    RAM output data is ignored.
//  - Back-to-back: a new grant in the response cycle is legal. Full throughput is
//    one access per cycle. The response and the new ack may target the same
//    requester in the same cycle.
//  - Read-during-write, same address: the RAM returns the old data; the arbiter
//    passes it through unchanged.
//  - Reset mid-operation: any pending response is dropped and no m_resp_o pulse
//    follows. Requesters must reissue.
//  - Widths: adr/dat slices are taken as [k*W +: W]. No address translation.
// TESTING
//  1 Reset: rst_n=0 with all m_req_i=1 -> m_ack_o=0, m_resp_o=0, ram_we_o=0.
//    Release -> m_ack_o=0b01 (rr_ptr=0).
//  2 Single read: m0 reads adr 5, RAM word 5 = 0xDEADBEEF -> ack[0] in cycle t.
//    resp[0]=1 with m_rdat_o=0xDEADBEEF in t+1. resp=0 in t+2.
//  3 Write then read: m1 writes 0x12345678 @ adr 9, then reads adr 9 ->
//    no resp for the write; resp[1] returns 0x12345678.
//  4 Fairness, NUM_M=4, all req held 1 for 8 cycles -> ack sequence
//    0,1,2,3,0,1,2,3 (one-hot); rr_ptr wraps 3->0.
//  5 Contention with pipelined reads: m0 and m1 read adr 1 (0xA) and 2 (0xB)
//    continuously -> alternating acks, resp each cycle from t+1, data 0xA/0xB
//    matched to the resp bit.
//  6 Reset mid-read: read acked at t, rst_n=0 in t+1 before the edge -> no
//    m_resp_o in t+1 or later; after release, rr_ptr=0 again.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter that shares one synchronous RAM port between NUM_M requesters.
// The RAM port is driven combinationally, and read responses come back one cycle after the grant.
module ram_port_arbiter #(
  parameter int NUM_M     = 2,
  parameter int dat_width = 32,
  parameter int adr_width = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_M-1:0]           m_req_i,
  input  logic [NUM_M-1:0]           m_we_i,
  input  logic [NUM_M*adr_width-1:0] m_adr_i,
  input  logic [NUM_M*dat_width-1:0] m_wdat_i,
  output logic [NUM_M-1:0]           m_ack_o,
  output logic [NUM_M-1:0]           m_resp_o,
  output logic [dat_width-1:0]       m_rdat_o,
  output logic [adr_width-1:0]       ram_adr_o,
  output logic                       ram_we_o,
  output logic [dat_width-1:0]       ram_dat_o,
  input  logic [dat_width-1:0]       ram_dat_i
);

  localparam int PW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        resp_id;
  logic                 resp_pend;
  logic                 grant;
  logic [PW-1:0]        g;
  logic [PW-1:0]        idx;
  logic [adr_width-1:0] adr_arr [NUM_M];
  logic [dat_width-1:0] wdat_arr [NUM_M];

  always_comb begin
    for (int k = 0; k < NUM_M; k++) begin
      adr_arr[k]  = m_adr_i[k*adr_width +: adr_width];
      wdat_arr[k] = m_wdat_i[k*dat_width +: dat_width];
    end
  end

  // First requester at or above rr_ptr wins, wrapping around; nothing is granted while in reset.
  always_comb begin
    grant = 1'b0;
    g     = '0;
    idx   = '0;
    for (int i = 0; i < NUM_M; i++) begin
      idx = PW'((int'(rr_ptr) + i) % NUM_M);
      if (!grant && m_req_i[idx]) begin
        grant = 1'b1;
        g     = idx;
      end
    end
    if (!rst_n) grant = 1'b0;
  end

  always_comb begin
    m_ack_o   = '0;
    ram_adr_o = '0;
    ram_we_o  = 1'b0;
    ram_dat_o = '0;
    if (grant) begin
      m_ack_o[g] = 1'b1;
      ram_adr_o  = adr_arr[g];
      ram_we_o   = m_we_i[g];
      ram_dat_o  = wdat_arr[g];
    end
  end

  always_comb begin
    m_resp_o = '0;
    if (resp_pend) m_resp_o[resp_id] = 1'b1;
  end

  assign m_rdat_o = ram_dat_i;

  // The response tracker follows the RAM's one-cycle registered read; writes never set it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      resp_pend <= 1'b0;
      resp_id   <= '0;
    end else if (grant) begin
      rr_ptr    <= (g == PW'(NUM_M - 1)) ? '0 : g + 1'b1;
      resp_pend <= ~m_we_i[g];
      resp_id   <= g;
    end else begin
      resp_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter with four requesters and a behavioural RAM.
// Stimulus pushes hand-computed grants and read responses, and a negedge monitor pops and checks them.
module tb_ram_port_arbiter;

  localparam int NM = 4;
  localparam int AW = 8;
  localparam int DW = 32;

  typedef struct {
    logic [NM-1:0] ack;
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] wdat;
  } ack_exp_t;

  typedef struct {
    int            due;
    logic [NM-1:0] resp;
    logic [DW-1:0] data;
  } resp_exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NM-1:0]     m_req;
  logic [NM-1:0]     m_we;
  logic [NM*AW-1:0]  m_adr;
  logic [NM*DW-1:0]  m_wdat;
  logic [NM-1:0]     m_ack;
  logic [NM-1:0]     m_resp;
  logic [DW-1:0]     m_rdat;
  logic [AW-1:0]     ram_adr;
  logic              ram_we;
  logic [DW-1:0]     ram_dat_o;
  logic [DW-1:0]     ram_dat_i = '0;

  logic [AW-1:0]     adr  [NM];
  logic [DW-1:0]     wdat [NM];
  logic [DW-1:0]     mem  [256];

  ack_exp_t  ack_q [$];
  resp_exp_t resp_q [$];
  int        cyc = 0;
  int        vec_count = 0;
  int        miss_count = 0;

  ram_port_arbiter #(.NUM_M(NM), .dat_width(DW), .adr_width(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m_req_i   (m_req),
    .m_we_i    (m_we),
    .m_adr_i   (m_adr),
    .m_wdat_i  (m_wdat),
    .m_ack_o   (m_ack),
    .m_resp_o  (m_resp),
    .m_rdat_o  (m_rdat),
    .ram_adr_o (ram_adr),
    .ram_we_o  (ram_we),
    .ram_dat_o (ram_dat_o),
    .ram_dat_i (ram_dat_i)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < NM; k++) begin
      m_adr[k*AW +: AW]  = adr[k];
      m_wdat[k*DW +: DW] = wdat[k];
    end
  end

  // Registered-read RAM with read-old-on-write, preloaded while in reset.
  always @(posedge clk) begin
    if (!rst_n) begin
      mem[1] <= 32'h0000_000A;
      mem[2] <= 32'h0000_000B;
      mem[5] <= 32'hDEAD_BEEF;
    end else if (ram_we) begin
      mem[ram_adr] <= ram_dat_o;
    end
    ram_dat_i <= mem[ram_adr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NM-1:0] req, input logic [NM-1:0] we,
                               input logic [NM-1:0] exp_ack, input bit exp_rd,
                               input logic [DW-1:0] exp_data);
    ack_exp_t  a;
    resp_exp_t r;
    int        gi;
    m_req = req;
    m_we  = we;
    if (req != '0) begin
      gi = 0;
      for (int k = 0; k < NM; k++) if (exp_ack[k]) gi = k;
      a.ack  = exp_ack;
      a.we   = we[gi];
      a.adr  = adr[gi];
      a.wdat = we[gi] ? wdat[gi] : '0;
      ack_q.push_back(a);
      if (exp_rd) begin
        r.due  = cyc + 1;
        r.resp = exp_ack;
        r.data = exp_data;
        resp_q.push_back(r);
      end
    end
  endtask

  // Monitor: checks the RAM port against the grant queue and read data against the response queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_req != '0) begin
        if (ack_q.size() == 0) begin
          vec_count++;
          miss_count++;
          $display("[TB] FAIL ack_unexpected: got %b expected no entry", m_ack);
        end else begin
          ack_exp_t a;
          a = ack_q.pop_front();
          checkOutput("ack", DW'(m_ack), DW'(a.ack));
          checkOutput("ram_we", DW'(ram_we), DW'(a.we));
          checkOutput("ram_adr", DW'(ram_adr), DW'(a.adr));
          if (a.we) checkOutput("ram_dat", ram_dat_o, a.wdat);
        end
      end else begin
        checkOutput("idle_ack", DW'(m_ack), '0);
        checkOutput("idle_we", DW'(ram_we), '0);
      end
      if (resp_q.size() != 0 && resp_q[0].due == cyc) begin
        resp_exp_t r;
        r = resp_q.pop_front();
        checkOutput("resp", DW'(m_resp), DW'(r.resp));
        checkOutput("rdat", m_rdat, r.data);
      end else if (m_resp != '0) begin
        vec_count++;
        miss_count++;
        $display("[TB] FAIL resp_unexpected: got %b expected 0000", m_resp);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    m_req = '1;
    m_we  = '1;
    for (int k = 0; k < NM; k++) begin
      adr[k]  = '0;
      wdat[k] = 32'h5555_0000 + k;
    end

    // Reset with every requester asking: nothing granted, nothing written.
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ack", DW'(m_ack), '0);
    checkOutput("rst_resp", DW'(m_resp), '0);
    checkOutput("rst_we", DW'(ram_we), '0);

    tick();
    rst_n  = 1'b1;
    adr[0] = 8'd5;
    applyStimulus(4'b1111, 4'b0000, 4'b0001, 1'b1, 32'hDEAD_BEEF);
    tick(); applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0, '0);

    // Single read from m0 (pointer now at 1, wraps to m0).
    tick(); applyStimulus(4'b0001, 4'b0000, 4'b0001, 1'b1, 32'hDEAD_BEEF);
    tick(); applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0, '0);
    tick(); applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0, '0);

    // m1 writes then reads back address 9.
    adr[1]  = 8'd9;
    wdat[1] = 32'h1234_5678;
    tick(); applyStimulus(4'b0010, 4'b0010, 4'b0010, 1'b0, '0);
    tick(); applyStimulus(4'b0010, 4'b0000, 4'b0010, 1'b1, 32'h1234_5678);
    tick(); applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0, '0);

    // Reset right after an acked read: the response must never appear.
    adr[2] = 8'd5;
    tick(); applyStimulus(4'b0100, 4'b0000, 4'b0100, 1'b0, '0);
    tick();
    rst_n = 1'b0;
    m_req = '0;
    m_we  = '0;
    @(negedge clk);
    checkOutput("midrst_resp", DW'(m_resp), '0);
    tick();
    rst_n = 1'b1;
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0, '0);
    tick(); applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0, '0);

    // Fairness: all four write continuously, pointer restarts at 0.
    for (int k = 0; k < NM; k++) begin
      adr[k]  = 8'd20 + 8'(k);
      wdat[k] = 32'hC0DE_0000 + k;
    end
    for (int n = 0; n < 8; n++) begin
      logic [NM-1:0] exp_ack;
      exp_ack = 4'b0001 << (n % 4);
      tick(); applyStimulus(4'b1111, 4'b1111, exp_ack, 1'b0, '0);
    end

    // Pipelined contention between m0 (adr 1) and m1 (adr 2).
    adr[0] = 8'd1;
    adr[1] = 8'd2;
    for (int n = 0; n < 6; n++) begin
      if (n % 2 == 0) begin
        tick(); applyStimulus(4'b0011, 4'b0000, 4'b0001, 1'b1, 32'h0000_000A);
      end else begin
        tick(); applyStimulus(4'b0011, 4'b0000, 4'b0010, 1'b1, 32'h0000_000B);
      end
    end
    tick(); applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0, '0);
    tick(); applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0, '0);
    tick();

    checkOutput("resp_q_empty", DW'(resp_q.size()), '0);
    checkOutput("ack_q_empty", DW'(ack_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
